// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the decoded control bundle pipeline of the 5-stage CPU.
package ctrl_pipe_pkg;

  localparam int STG_E = 0;
  localparam int STG_M = 1;
  localparam int STG_W = 2;

  // Control-bit positions inside one 8-bit bundle (bit 0 is the memory enable).
  localparam int MEMEN    = 0;
  localparam int REGWRITE = 1;
  localparam int REGDST   = 2;
  localparam int ALUSRC   = 3;
  localparam int MEMWRITE = 4;
  localparam int MEMTOREG = 5;
  localparam int BRANCH   = 6;
  localparam int JUMP     = 7;

  localparam logic [7:0] MASK_E = 8'hFF;
  localparam logic [7:0] MASK_M = (8'h1 << MEMEN) | (8'h1 << REGWRITE) |
                                  (8'h1 << MEMWRITE) | (8'h1 << MEMTOREG);
  localparam logic [7:0] MASK_W = (8'h1 << REGWRITE) | (8'h1 << MEMTOREG);

  localparam logic [23:0] CPU_STAGE_MASK = {MASK_W, MASK_M, MASK_E};

endpackage

// File: rtl/ctrl_stage_reg.sv
// One stage register of the control pipeline: bundle plus valid bit, with
// clear (flush), hold (stall) and bubble-insert controls.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int               SIG_W = 8,
  parameter logic [SIG_W-1:0] MASK  = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             bubble_i,
  input  logic [SIG_W-1:0] sig_i,
  input  logic             vld_i,
  output logic [SIG_W-1:0] sig_o,
  output logic             vld_o
);

  logic [SIG_W-1:0] sig_q, sig_d;
  logic             vld_q, vld_d;

  // Clear beats hold; an invalid input is zeroed so a bubble never carries enables.
  always_comb begin
    sig_d = sig_q;
    vld_d = vld_q;
    if (clr_i) begin
      sig_d = '0;
      vld_d = 1'b0;
    end else if (hold_i) begin
      sig_d = sig_q;
      vld_d = vld_q;
    end else if (bubble_i) begin
      sig_d = '0;
      vld_d = 1'b0;
    end else begin
      sig_d = sig_i & MASK & {SIG_W{vld_i}};
      vld_d = vld_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
      vld_q <= vld_d;
    end
  end

  assign sig_o = sig_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/ctrl_sig_pipe.sv
// Control-signal pipeline: DEPTH stage registers after Decode with stall/flush,
// per-stage masks and saturating retire/bubble counters at the last stage.
module ctrl_sig_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int                     SIG_W      = 8,
  parameter int                     DEPTH      = 3,
  parameter logic [DEPTH*SIG_W-1:0] STAGE_MASK = '1,
  parameter int                     CNT_W      = 16
) (
  input  logic                   clka,
  input  logic                   rst,
  input  logic [SIG_W-1:0]       sig_d,
  input  logic                   valid_d,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   clr_cnt,
  output logic [DEPTH*SIG_W-1:0] sig_q,
  output logic [DEPTH-1:0]       valid_q,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       bubble_cnt
);

  localparam int LAST = DEPTH - 1;

  logic [DEPTH-1:0]            hold, bubble, in_vld, st_vld;
  logic [DEPTH-1:0][SIG_W-1:0] in_sig, st_sig;

  // A stall anywhere downstream freezes every register feeding it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc     = acc | stall[k];
      hold[k] = acc;
    end
  end

  // A stage whose upstream neighbour holds receives a bubble; stage 0 never does.
  assign bubble = hold << 1;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stg
    if (k == 0) begin : g_src
      assign in_sig[k] = sig_d;
      assign in_vld[k] = valid_d;
    end else begin : g_src
      assign in_sig[k] = st_sig[k-1];
      assign in_vld[k] = st_vld[k-1];
    end

    ctrl_stage_reg #(
      .SIG_W (SIG_W),
      .MASK  (STAGE_MASK[k*SIG_W +: SIG_W])
    ) u_reg (
      .clk      (clka),
      .rst_n    (rst),
      .clr_i    (flush[k]),
      .hold_i   (hold[k]),
      .bubble_i (bubble[k]),
      .sig_i    (in_sig[k]),
      .vld_i    (in_vld[k]),
      .sig_o    (st_sig[k]),
      .vld_o    (st_vld[k])
    );
  end

  assign sig_q   = st_sig;
  assign valid_q = st_vld;

  logic             cnt_upd, new_vld;
  logic [CNT_W-1:0] retire_q, retire_d, bubble_q, bubble_d;

  // The value the last register is about to load decides which counter moves.
  assign cnt_upd = !hold[LAST];
  assign new_vld = in_vld[LAST] & !bubble[LAST] & !flush[LAST];

  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (clr_cnt) begin
      retire_d = '0;
      bubble_d = '0;
    end else if (cnt_upd) begin
      if (new_vld && !(&retire_q))
        retire_d = retire_q + CNT_W'(1);
      if (!new_vld && !(&bubble_q))
        bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ctrl_sig_pipe.sv
// Bench for ctrl_sig_pipe: directed vector table, corner sequences and random
// traffic, checked against a stage-array reference model for two configurations.
module tb_ctrl_sig_pipe;

  logic        clka, rst, valid_d, clr_cnt;
  logic [7:0]  sig_d;
  logic [2:0]  stall, flush;
  logic [23:0] sig_q0, sig_q1;
  logic [2:0]  vq0, vq1;
  logic [15:0] ret0, bub0;
  logic [3:0]  ret1, bub1;

  localparam logic [23:0] MASK0 = 24'hFFFFFF;
  localparam logic [23:0] MASK1 = 24'h03FFFF;

  ctrl_sig_pipe #(.SIG_W(8), .DEPTH(3), .STAGE_MASK(MASK0), .CNT_W(16)) dut (
    .clka(clka), .rst(rst), .sig_d(sig_d), .valid_d(valid_d), .stall(stall),
    .flush(flush), .clr_cnt(clr_cnt), .sig_q(sig_q0), .valid_q(vq0),
    .retire_cnt(ret0), .bubble_cnt(bub0));

  ctrl_sig_pipe #(.SIG_W(8), .DEPTH(3), .STAGE_MASK(MASK1), .CNT_W(4)) dut_m (
    .clka(clka), .rst(rst), .sig_d(sig_d), .valid_d(valid_d), .stall(stall),
    .flush(flush), .clr_cnt(clr_cnt), .sig_q(sig_q1), .valid_q(vq1),
    .retire_cnt(ret1), .bubble_cnt(bub1));

  initial clka = 1'b0;
  always #5 clka = ~clka;

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: stage contents per configuration, counters as plain ints.
  logic [7:0] m_sig [2][3];
  logic       m_vld [2][3];
  int         m_ret [2];
  int         m_bub [2];
  int         cmax  [2] = '{65535, 15};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        m_sig[i][k] = '0;
        m_vld[i][k] = 1'b0;
      end
      m_ret[i] = 0;
      m_bub[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [7:0]  ns [3];
      logic        nv [3];
      logic [23:0] msk;
      logic        hk, hp;
      msk = (i == 0) ? MASK0 : MASK1;
      for (int k = 0; k < 3; k++) begin
        hk = (stall >> k) != 0;
        hp = (k > 0) ? ((stall >> (k - 1)) != 0) : 1'b0;
        if (flush[k]) begin
          ns[k] = 8'h00; nv[k] = 1'b0;
        end else if (hk) begin
          ns[k] = m_sig[i][k]; nv[k] = m_vld[i][k];
        end else if (hp) begin
          ns[k] = 8'h00; nv[k] = 1'b0;
        end else if (k == 0) begin
          nv[k] = valid_d;
          ns[k] = valid_d ? (sig_d & msk[7:0]) : 8'h00;
        end else begin
          nv[k] = m_vld[i][k-1];
          ns[k] = m_sig[i][k-1] & msk[k*8 +: 8];
        end
      end
      if (clr_cnt) begin
        m_ret[i] = 0;
        m_bub[i] = 0;
      end else if (stall[2] == 1'b0) begin
        if (nv[2]) m_ret[i] = (m_ret[i] < cmax[i]) ? m_ret[i] + 1 : cmax[i];
        else       m_bub[i] = (m_bub[i] < cmax[i]) ? m_bub[i] + 1 : cmax[i];
      end
      for (int k = 0; k < 3; k++) begin
        m_sig[i][k] = ns[k];
        m_vld[i][k] = nv[k];
      end
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " d0 sig"}, sig_q0, {m_sig[0][2], m_sig[0][1], m_sig[0][0]});
    chk({tag, " d0 vld"}, vq0, {m_vld[0][2], m_vld[0][1], m_vld[0][0]});
    chk({tag, " d0 ret"}, ret0, m_ret[0]);
    chk({tag, " d0 bub"}, bub0, m_bub[0]);
    chk({tag, " d1 sig"}, sig_q1, {m_sig[1][2], m_sig[1][1], m_sig[1][0]});
    chk({tag, " d1 vld"}, vq1, {m_vld[1][2], m_vld[1][1], m_vld[1][0]});
    chk({tag, " d1 ret"}, ret1, m_ret[1]);
    chk({tag, " d1 bub"}, bub1, m_bub[1]);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, compare at the next fall.
  task automatic tick(input logic [7:0] s, input logic v, input logic [2:0] st,
                      input logic [2:0] fl, input logic c, input string tag);
    sig_d = s; valid_d = v; stall = st; flush = fl; clr_cnt = c;
    model_step();
    @(posedge clka);
    @(negedge clka);
    cmp_model(tag);
  endtask

  typedef struct {
    logic [7:0]  s;
    logic        v;
    logic [2:0]  st;
    logic [2:0]  fl;
    logic        c;
    logic [23:0] e_sig;
    logic [2:0]  e_vld;
    int          e_ret;
    int          e_bub;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // stream, stall[0] bubbles, flush+stall on E, non-monotonic stall, W flush, clear
    tbl[0]  = '{8'hA5, 1'b1, 3'b000, 3'b000, 1'b0, 24'h0000A5, 3'b001, 0, 1};
    tbl[1]  = '{8'h3C, 1'b1, 3'b000, 3'b000, 1'b0, 24'h00A53C, 3'b011, 0, 2};
    tbl[2]  = '{8'h0F, 1'b1, 3'b000, 3'b000, 1'b0, 24'hA53C0F, 3'b111, 1, 2};
    tbl[3]  = '{8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 24'h3C0F00, 3'b110, 2, 2};
    tbl[4]  = '{8'h00, 1'b0, 3'b000, 3'b000, 1'b0, 24'h0F0000, 3'b100, 3, 2};
    tbl[5]  = '{8'h77, 1'b1, 3'b000, 3'b000, 1'b0, 24'h000077, 3'b001, 3, 3};
    tbl[6]  = '{8'h11, 1'b1, 3'b001, 3'b000, 1'b0, 24'h000077, 3'b001, 3, 4};
    tbl[7]  = '{8'h11, 1'b1, 3'b001, 3'b000, 1'b0, 24'h000077, 3'b001, 3, 5};
    tbl[8]  = '{8'h22, 1'b1, 3'b000, 3'b000, 1'b0, 24'h007722, 3'b011, 3, 6};
    tbl[9]  = '{8'h5A, 1'b1, 3'b000, 3'b000, 1'b0, 24'h77225A, 3'b111, 4, 6};
    tbl[10] = '{8'h99, 1'b1, 3'b001, 3'b001, 1'b0, 24'h220000, 3'b100, 5, 6};
    tbl[11] = '{8'h99, 1'b1, 3'b000, 3'b000, 1'b0, 24'h000099, 3'b001, 5, 7};
    tbl[12] = '{8'h44, 1'b1, 3'b000, 3'b000, 1'b0, 24'h009944, 3'b011, 5, 8};
    tbl[13] = '{8'h55, 1'b1, 3'b100, 3'b000, 1'b0, 24'h009944, 3'b011, 5, 8};
    tbl[14] = '{8'h55, 1'b1, 3'b000, 3'b000, 1'b0, 24'h994455, 3'b111, 6, 8};
    tbl[15] = '{8'h66, 1'b1, 3'b100, 3'b100, 1'b0, 24'h004455, 3'b011, 6, 8};
    tbl[16] = '{8'h66, 1'b1, 3'b000, 3'b010, 1'b0, 24'h440066, 3'b101, 7, 8};
    tbl[17] = '{8'h00, 1'b0, 3'b000, 3'b000, 1'b1, 24'h006600, 3'b010, 0, 0};
    tbl[18] = '{8'hAB, 1'b0, 3'b000, 3'b000, 1'b0, 24'h660000, 3'b100, 1, 0};

    rst = 1'b0; sig_d = '0; valid_d = 1'b0; stall = '0; flush = '0; clr_cnt = 1'b0;
    model_reset();
    @(negedge clka);
    @(negedge clka);
    chk("reset sig", sig_q0, 24'h0);
    chk("reset vld", vq0, 3'b000);
    chk("reset ret", ret0, 0);
    chk("reset bub", bub0, 0);
    cmp_model("reset");
    rst = 1'b1;

    for (int r = 0; r < 19; r++) begin
      tick(tbl[r].s, tbl[r].v, tbl[r].st, tbl[r].fl, tbl[r].c, $sformatf("row%0d", r));
      chk($sformatf("tbl%0d sig", r), sig_q0, tbl[r].e_sig);
      chk($sformatf("tbl%0d vld", r), vq0, tbl[r].e_vld);
      chk($sformatf("tbl%0d ret", r), ret0, tbl[r].e_ret);
      chk($sformatf("tbl%0d bub", r), bub0, tbl[r].e_bub);
    end

    // Masked W slice and counter saturation on the narrow-counter instance.
    for (int i = 0; i < 3; i++) tick(8'hFF, 1'b1, 3'b000, 3'b000, 1'b0, "maskfill");
    chk("mask W full", sig_q0[23:16], 8'hFF);
    chk("mask W 03", sig_q1[23:16], 8'h03);
    for (int i = 0; i < 20; i++) tick(8'h12, 1'b1, 3'b001, 3'b000, 1'b0, "satrun");
    chk("bub sat", bub1, 4'hF);
    tick(8'h12, 1'b1, 3'b001, 3'b000, 1'b0, "sathold");
    chk("bub sat hold", bub1, 4'hF);
    tick(8'h12, 1'b1, 3'b001, 3'b000, 1'b1, "clr");
    chk("bub clr", bub1, 4'h0);
    chk("ret clr", ret0, 16'h0);

    for (int n = 0; n < 400; n++) begin
      logic [2:0] st, fl;
      for (int b = 0; b < 3; b++) begin
        st[b] = ($urandom_range(0, 4) == 0);
        fl[b] = ($urandom_range(0, 7) == 0);
      end
      tick(8'($urandom), ($urandom_range(0, 3) != 0), st, fl,
           ($urandom_range(0, 39) == 0), "rand");
    end

    // Asynchronous reset between edges, then first valid result at W 3 edges later.
    for (int i = 0; i < 3; i++) tick(8'h3D, 1'b1, 3'b000, 3'b000, 1'b0, "prerst");
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("async rst sig", sig_q0, 24'h0);
    chk("async rst vld", vq0, 3'b000);
    chk("async rst ret", ret0, 0);
    cmp_model("asyncrst");
    @(negedge clka);
    rst = 1'b1;
    tick(8'hC3, 1'b1, 3'b000, 3'b000, 1'b0, "post1");
    chk("post1 W vld", vq0[2], 1'b0);
    tick(8'h00, 1'b0, 3'b000, 3'b000, 1'b0, "post2");
    chk("post2 W vld", vq0[2], 1'b0);
    tick(8'h00, 1'b0, 3'b000, 3'b000, 1'b0, "post3");
    chk("post3 W vld", vq0[2], 1'b1);
    chk("post3 W sig", sig_q0[23:16], 8'hC3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
